// File: rtl/sipo_frame_deserializer.sv
// Serial MSB-first word assembler with frame_start alignment,
// one-entry valid/ready output register and sticky error flags.
module sipo_frame_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             frame_error,
  input  logic             clear_flags
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-2:0] shift, shift_n;
  logic [CW-1:0]    count, count_n;
  logic             word_done;
  logic             resync;
  logic [WIDTH-1:0] word;

  logic load;
  logic drop;
  logic accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      count <= count_n;
    end
  end

  // shift holds the first WIDTH-1 bits right-aligned
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    count_n   = count;
    word_done = 1'b0;
    resync    = 1'b0;
    word      = {shift, serial_in};
    if (bit_valid) begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            shift_n    = '0;
            shift_n[0] = serial_in;
            count_n    = CW'(1);
            state_n    = SHIFT;
          end
        end
        SHIFT: begin
          if (frame_start) begin
            resync     = 1'b1;
            shift_n    = '0;
            shift_n[0] = serial_in;
            count_n    = CW'(1);
          end else if (count == CW'(WIDTH - 1)) begin
            word_done = 1'b1;
            shift_n   = '0;
            count_n   = '0;
            state_n   = IDLE;
          end else begin
            shift_n    = shift << 1;
            shift_n[0] = serial_in;
            count_n    = count + CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign accept = data_valid & data_ready;
  assign load   = word_done & (~data_valid | data_ready);
  assign drop   = word_done & data_valid & ~data_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (load) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (accept) begin
        data_valid <= 1'b0;
      end
      // a set event in the same cycle beats clear_flags
      if (drop)
        overrun <= 1'b1;
      else if (clear_flags)
        overrun <= 1'b0;
      if (resync)
        frame_error <= 1'b1;
      else if (clear_flags)
        frame_error <= 1'b0;
    end
  end

endmodule
